// File: rtl/icache_fill.sv
// Direct-mapped one-word instruction cache with a single-request fill engine.
// Hits return in the fetch cycle. A miss holds the fetch in FILL until memory has asserted iwait and then released it.
module icache_fill #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state, next_state;
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tags [SETS];
  logic [31:0]     data [SETS];
  logic [31:0]     miss_addr;
  logic            seen_wait;

  logic [IW-1:0]   idx, fidx;
  logic [TW-1:0]   tag_in, ftag;
  logic            lookup, start_miss, fill_done;
  logic            unused_bits;

  assign idx         = imemaddr[IW+1:2];
  assign tag_in      = imemaddr[31:IW+2];
  assign fidx        = miss_addr[IW+1:2];
  assign ftag        = miss_addr[31:IW+2];
  assign lookup      = valid[idx] && (tags[idx] == tag_in);
  assign unused_bits = ^imemaddr[1:0];

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = 32'h0;
    iREN       = 1'b0;
    iaddr      = 32'h0;
    start_miss = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (imemREN && !flush) begin
          if (lookup) begin
            ihit     = 1'b1;
            imemload = data[idx];
          end else begin
            start_miss = 1'b1;
            next_state = FILL;
          end
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        // The iwait=0 seen before memory has ever gone busy is not the data beat.
        if (!iwait && seen_wait) begin
          fill_done  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      valid      <= '0;
      seen_wait  <= 1'b0;
      miss_addr  <= 32'h0;
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      state <= next_state;
      if (start_miss) begin
        miss_addr <= {imemaddr[31:2], 2'b00};
        seen_wait <= 1'b0;
      end else if (state == FILL && iwait) begin
        seen_wait <= 1'b1;
      end
      // Flush beats a same-cycle fill: the entry stays invalid.
      if (flush)
        valid <= '0;
      else if (fill_done)
        valid[fidx] <= 1'b1;
      if (ihit && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 32'd1;
      if (start_miss && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[fidx] <= ftag;
      data[fidx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_fill.sv
// Directed bench for icache_fill: cold miss, early-zero iwait, conflict, flush, reset mid-fill, address change.
module tb_icache_fill;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  icache_fill #(.SETS(16)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked mid-cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; flush = 1'b0; iwait = 1'b0; iload = 32'h0;
    #2;
    check("rst_ihit", {31'b0, ihit}, 32'h0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_iren", {31'b0, iREN}, 32'h0);
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_hits", hit_count, 32'h0);
    check("rst_misses", miss_count, 32'h0);
    tick(); RST = 1'b0;

    // Cold miss at 0x40 with iwait 0,1,1,0; the early zero carries junk data.
    imemREN = 1'b1; imemaddr = 32'h40; settle();
    check("cold_req_ihit", {31'b0, ihit}, 32'h0);
    check("cold_req_iren", {31'b0, iREN}, 32'h0);
    tick(); iwait = 1'b0; iload = 32'hDEAD; settle();
    check("cold_fill_iren", {31'b0, iREN}, 32'h1);
    check("cold_fill_iaddr", iaddr, 32'h40);
    check("cold_fill_ihit", {31'b0, ihit}, 32'h0);
    check("cold_misses", miss_count, 32'h1);
    tick(); iwait = 1'b1; settle();
    check("early_zero_no_done", {31'b0, iREN}, 32'h1);
    tick(); iwait = 1'b1;
    tick(); iwait = 1'b0; iload = 32'h2001_000A; settle();
    check("cold_done_iren", {31'b0, iREN}, 32'h1);
    tick(); iload = 32'h0; settle();
    check("cold_hit", {31'b0, ihit}, 32'h1);
    check("cold_hit_data", imemload, 32'h2001_000A);
    check("cold_idle_iren", {31'b0, iREN}, 32'h0);
    check("cold_idle_iaddr", iaddr, 32'h0);
    tick(); imemREN = 1'b0; settle();
    check("cold_hits", hit_count, 32'h1);
    check("noreq_imemload", imemload, 32'h0);

    // Conflict: 0x80 shares index 0 with 0x40 and evicts it.
    tick(); imemREN = 1'b1; imemaddr = 32'h80;
    tick(); iwait = 1'b1;
    tick(); iwait = 1'b0; iload = 32'h8080_8080;
    tick(); settle();
    check("conf_80_hit", {31'b0, ihit}, 32'h1);
    check("conf_80_data", imemload, 32'h8080_8080);
    check("conf_misses2", miss_count, 32'h2);
    tick(); imemaddr = 32'h40; settle();
    check("conf_40_evicted", {31'b0, ihit}, 32'h0);
    check("conf_hits2", hit_count, 32'h2);
    tick(); settle();
    check("conf_misses3", miss_count, 32'h3);
    iwait = 1'b1;
    tick(); iwait = 1'b0; iload = 32'h2001_000A;
    tick(); settle();
    check("conf_40_rehit", {31'b0, ihit}, 32'h1);

    // Flush on a valid hit: hit suppressed, no miss started, next fetch misses.
    tick(); flush = 1'b1; settle();
    check("flush_ihit", {31'b0, ihit}, 32'h0);
    check("flush_hits", hit_count, 32'h3);
    tick(); flush = 1'b0; settle();
    check("flush_no_miss", miss_count, 32'h3);
    check("flush_then_miss", {31'b0, ihit}, 32'h0);
    check("flush_idle_iren", {31'b0, iREN}, 32'h0);
    tick(); iwait = 1'b1; settle();
    check("flush_misses4", miss_count, 32'h4);
    tick(); iwait = 1'b0; iload = 32'h1111_2222;
    tick(); settle();
    check("flush_refill_data", imemload, 32'h1111_2222);

    // Flush on the completion cycle leaves the filled entry invalid.
    tick(); imemaddr = 32'h48;
    tick(); iwait = 1'b1;
    tick(); iwait = 1'b0; iload = 32'h4848_4848; flush = 1'b1;
    tick(); flush = 1'b0; settle();
    check("flush_done_state", {31'b0, iREN}, 32'h0);
    check("flush_done_invalid", {31'b0, ihit}, 32'h0);
    tick(); iwait = 1'b1;
    tick(); iwait = 1'b0;
    tick(); settle();
    check("flush_done_refill", {31'b0, ihit}, 32'h1);

    // Reset mid-fill drops iREN at once and writes nothing.
    tick(); imemaddr = 32'hC0;
    tick(); iwait = 1'b1;
    tick(); settle();
    check("rstfill_iren_before", {31'b0, iREN}, 32'h1);
    RST = 1'b1; #1;
    check("rstfill_iren_async", {31'b0, iREN}, 32'h0);
    check("rstfill_misses0", miss_count, 32'h0);
    check("rstfill_hits0", hit_count, 32'h0);
    tick(); RST = 1'b0; iwait = 1'b0; imemaddr = 32'h40; settle();
    check("rstfill_40_miss", {31'b0, ihit}, 32'h0);

    // Address change during fill: iaddr holds 0x40, then 0x44 misses.
    tick(); imemaddr = 32'h44; iwait = 1'b1; settle();
    check("rstfill_misses1", miss_count, 32'h1);
    check("chg_iaddr_hold", iaddr, 32'h40);
    tick(); iwait = 1'b0; iload = 32'hAAAA_0040; settle();
    check("chg_iaddr_done", iaddr, 32'h40);
    tick(); settle();
    check("chg_44_miss", {31'b0, ihit}, 32'h0);
    tick(); iwait = 1'b1; settle();
    check("chg_44_iaddr", iaddr, 32'h44);
    tick(); iwait = 1'b0; iload = 32'hBBBB_0044;
    tick(); imemaddr = 32'h40; settle();
    check("chg_40_data", imemload, 32'hAAAA_0040);
    tick(); imemaddr = 32'h44; settle();
    check("chg_44_data", imemload, 32'hBBBB_0044);
    tick(); imemREN = 1'b0; settle();
    check("final_hits", hit_count, 32'h2);
    check("final_misses", miss_count, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/icache_fill.md
ICACHE_FILL -- requirements
Module: icache_fill

Interface
REQ-001 SHALL have parameter: SETS, 16, number of direct-mapped one-word sets (power of 2, 2..64).
REQ-002 SHALL have port: CLK  input  1  sole clock, rising-edge.
REQ-003 SHALL have port: RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: imemREN  input  1  datapath instruction fetch request.
REQ-005 SHALL have port: imemaddr  input  32  datapath fetch byte address.
REQ-006 SHALL have port: ihit  output  1  fetch hit, imemload valid this cycle.
REQ-007 SHALL have port: imemload  output  32  instruction returned to datapath.
REQ-008 SHALL have port: flush  input  1  invalidate all sets.
REQ-009 SHALL have port: iREN  output  1  read request to memory control.
REQ-010 SHALL have port: iaddr  output  32  word address to memory control.
REQ-011 SHALL have port: iwait  input  1  memory control busy.
REQ-012 SHALL have port: iload  input  32  memory control read data.
REQ-013 SHALL have ports: hit_count, miss_count  output  32  each, performance counters.
REQ-014 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-015 SHALL decode imemaddr as tag [31:2+log2(SETS)], index [1+log2(SETS):2], bits [1:0] ignored.
REQ-016 SHALL store per set: valid (1), tag, data (32).
REQ-017 SHALL implement two states: IDLE, FILL.
REQ-018 IDLE: ihit=1 combinationally when imemREN=1 and valid[index]=1 and tag matches; imemload=data[index]; else ihit=0, imemload=0.
REQ-019 IDLE: on imemREN=1 with miss and flush=0, SHALL latch {imemaddr[31:2],2'b00} into miss_addr and move to FILL next edge.
REQ-020 FILL: iREN=1, iaddr=miss_addr, ihit=0; iREN=0 and iaddr=0 in IDLE.
REQ-021 FILL: SHALL set internal seen_wait when iwait=1; seen_wait cleared on entry to FILL.
REQ-022 FILL SHALL complete only on a cycle with iwait=0 and seen_wait=1 (first iwait=0 cycle of a request is not data); on completion write tag/data=iload/valid=1 to miss_addr's set and return to IDLE.
REQ-023 Minimum miss latency: request cycle, >=1 iwait=1 cycle, 1 completion cycle, then hit the following IDLE cycle.
REQ-024 Changes of imemREN/imemaddr during FILL SHALL NOT abort the fill; the filled entry uses miss_addr.
REQ-025 flush=1 SHALL clear all valid bits at the edge, in any state; ihit forced 0 that cycle; no miss is started that cycle.
REQ-026 flush=1 on a FILL completion cycle: fill completes, returns to IDLE, but entry is left invalid (flush wins).
REQ-027 hit_count SHALL increment on each cycle ihit=1; miss_count on each IDLE->FILL transition; both saturate at 32'hFFFFFFFF.
REQ-028 Refill of an occupied set SHALL overwrite it (no replacement choice).

Reset
REQ-029 RST=1 SHALL asynchronously force state=IDLE, all valid=0, seen_wait=0, miss_addr=0, hit_count=0, miss_count=0.
REQ-030 During and after reset until first miss: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-031 RST asserted mid-FILL SHALL abandon the fill with no entry written; iREN drops asynchronously.
REQ-032 Tag/data arrays need not be reset.

Verification
REQ-033 Cold miss: imemREN=1, imemaddr=0x40; memory iwait 0,1,1,0 with iload=0x2001000A -> iREN/iaddr=0x40 during FILL, entry written, next cycle ihit=1, imemload=0x2001000A, miss_count=1, hit_count=1.
REQ-034 Early-zero iwait: FILL first cycle iwait=0, iload=0xDEAD -> no completion; data taken only after iwait 1->0.
REQ-035 Conflict: fill 0x40 then 0x80 (SETS=16, same index 0) -> 0x80 evicts 0x40; re-fetch 0x40 misses, miss_count=3.
REQ-036 Flush: after valid hit at 0x40, flush=1 one cycle -> ihit=0; next fetch of 0x40 misses.
REQ-037 Reset mid-FILL: RST=1 while iwait=1 -> iREN=0 immediately; after release fetch of same address misses, counters 0 then 1.
REQ-038 Address change during FILL: imemaddr 0x40->0x44 mid-fill -> iaddr stays 0x40; 0x40 filled, then 0x44 misses.
